data_ram_banked: RTL and testbench

- Parametrised byte-lane data memory for the MEM stage. Successor to the fixed 32-bit, 4-lane data RAM.
- Adds configurable data width and depth, and a valid/ready request/response handshake with backpressure.
- Does store lane steering and load extraction/sign-extension internally, from access size and address.
- Flags misaligned and out-of-range accesses instead of silently aliasing.

---
 rtl/data_ram_banked_pkg.sv | 25 ++
 rtl/data_ram_lane.sv | 25 ++
 rtl/data_ram_banked.sv | 134 +++++++++++++
 tb/tb_data_ram_banked.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_banked_pkg.sv
// Shared encodings and helpers for the banked byte-lane data RAM.
// Lane/offset geometry derives from DATA_W at each instantiation.
package data_ram_banked_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  localparam int MAX_LANES = 8;
  localparam int MAX_OFF_W = 3;

  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_w_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic logic [3:0] bytes_of(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/data_ram_lane.sv
// One byte-wide single-port lane array with synchronous,
// enable-gated read.
module data_ram_lane #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  logic [7:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_ram_banked.sv
// MEM-stage data RAM: byte lanes, size/offset steering,
// load extension and a one-deep valid/ready response.
module data_ram_banked
  import data_ram_banked_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int ADDR_W      = 32,
  parameter int CHECK_RANGE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int LANES  = lanes_of(DATA_W);
  localparam int OFF_W  = off_w_of(DATA_W);
  localparam int IDX_HI = DEPTH_LOG2 + OFF_W;

  logic                  accept;
  logic                  err;
  logic [OFF_W-1:0]      off;
  logic [DEPTH_LOG2-1:0] widx;
  logic [3:0]            nbytes;
  logic [LANES-1:0]      lane_mask;
  logic [DATA_W-1:0]     wsh;
  logic [DATA_W-1:0]     raw;
  logic [DATA_W-1:0]     sh;
  logic [DATA_W-1:0]     mask;
  logic [DATA_W-1:0]     ext;

  logic              r_we;
  logic              r_err;
  logic              r_uns;
  logic [1:0]        r_size;
  logic [OFF_W-1:0]  r_off;
  logic              held;
  logic [DATA_W-1:0] hold_data;

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;
  assign off       = req_addr[OFF_W-1:0];
  assign widx      = req_addr[IDX_HI-1:OFF_W];
  assign nbytes    = bytes_of(req_size);
  assign wsh       = req_wdata << {off, 3'b000};

  always_comb begin
    err = 1'b0;
    if ((off & OFF_W'(nbytes - 4'd1)) != '0) begin
      err = 1'b1;
    end
    if (req_size == SZ_DWORD && DATA_W == 32) begin
      err = 1'b1;
    end
    if (CHECK_RANGE != 0 && (req_addr >> IDX_HI) != '0) begin
      err = 1'b1;
    end
    lane_mask = LANES'((16'd1 << nbytes) - 16'd1) << off;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    data_ram_lane #(
      .DEPTH_LOG2(DEPTH_LOG2)
    ) u_lane (
      .clk  (clk),
      .en   (accept),
      .we   (accept && req_we && lane_mask[i] && !err),
      .addr (widx),
      .wdata(wsh[8*i +: 8]),
      .rdata(raw[8*i +: 8])
    );
  end

  // Extension width comes from the size captured at accept.
  always_comb begin
    int nbits;
    int sb;
    nbits = 8 * int'(bytes_of(r_size));
    sb    = (nbits > DATA_W) ? DATA_W - 1 : nbits - 1;
    sh    = raw >> {r_off, 3'b000};
    mask  = '1;
    if (nbits < DATA_W) begin
      mask = ~({DATA_W{1'b1}} << nbits);
    end
    ext = sh & mask;
    if (!r_uns && sh[sb]) begin
      ext = ext | ~mask;
    end
    if (r_we || r_err) begin
      ext = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= SZ_BYTE;
      r_off      <= '0;
      held       <= 1'b0;
      hold_data  <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      r_we       <= req_we;
      r_err      <= err;
      r_uns      <= req_unsigned;
      r_size     <= req_size;
      r_off      <= off;
      held       <= 1'b0;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
      held       <= 1'b0;
    end else if (resp_valid && !held) begin
      held      <= 1'b1;
      hold_data <= ext;
    end
  end

  assign resp_rdata = !resp_valid ? '0 : (held ? hold_data : ext);
  assign resp_err   = r_err;

endmodule

// File: tb/tb_data_ram_banked.sv
// Bench for data_ram_banked: vector tables, hand sequences
// and randomized traffic against a byte-array model.
module tb_data_ram_banked;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic        d_req_we = 1'b0;
  logic [31:0] d_req_addr = '0;
  logic [1:0]  d_req_size = '0;
  logic        d_req_unsigned = 1'b0;
  logic [63:0] d_req_wdata = '0;
  logic        d_resp_valid;
  logic        d_resp_ready = 1'b1;
  logic [63:0] d_resp_rdata;
  logic        d_resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_ram_banked #(
    .DATA_W(32), .DEPTH_LOG2(6), .ADDR_W(32), .CHECK_RANGE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_ram_banked #(
    .DATA_W(64), .DEPTH_LOG2(4), .ADDR_W(32), .CHECK_RANGE(1)
  ) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(d_req_valid), .req_ready(d_req_ready),
    .req_we(d_req_we), .req_addr(d_req_addr),
    .req_size(d_req_size), .req_unsigned(d_req_unsigned),
    .req_wdata(d_req_wdata),
    .resp_valid(d_resp_valid), .resp_ready(d_resp_ready),
    .resp_rdata(d_resp_rdata), .resp_err(d_resp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wd;
    logic [63:0] rd;
    logic        er;
  } vec_t;

  vec_t tbl32 [16];
  vec_t tbl64 [7];

  logic [7:0] mem [0:255];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic m_err(input logic [31:0] a,
                                 input logic [1:0] sz);
    int nb;
    nb = 1 << sz;
    return (sz == 2'd3) || (a % nb != 0) || (a >= 256);
  endfunction

  task automatic m_do(input logic we, input logic [31:0] a,
                      input logic [1:0] sz, input logic u,
                      input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
    int nb;
    logic [31:0] v;
    nb = 1 << sz;
    er = m_err(a, sz);
    rd = '0;
    if (!er) begin
      if (we) begin
        for (int k = 0; k < nb; k++) mem[a + k] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < nb; k++) v |= 32'(mem[a + k]) << (8 * k);
        if (!u && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
        rd = v;
      end
    end
  endtask

  task automatic xact32(input logic we, input logic [31:0] a,
                        input logic [1:0] sz, input logic u,
                        input logic [31:0] wd, input int stall,
                        output logic [31:0] rd, output logic er,
                        output logic ok);
    logic [31:0] r0;
    int n;
    @(negedge clk);
    req_we = we; req_addr = a; req_size = sz;
    req_unsigned = u; req_wdata = wd;
    req_valid = 1'b1; resp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    resp_ready = (stall == 0);
    @(negedge clk);
    ok = ok && resp_valid;
    r0 = resp_rdata;
    repeat (stall) @(negedge clk);
    ok = ok && resp_valid && (resp_rdata == r0) &&
         (stall == 0 || !req_ready);
    rd = resp_rdata;
    er = resp_err;
    resp_ready = 1'b1;
  endtask

  task automatic xact64(input logic we, input logic [31:0] a,
                        input logic [1:0] sz, input logic u,
                        input logic [63:0] wd,
                        output logic [63:0] rd, output logic er,
                        output logic ok);
    @(negedge clk);
    d_req_we = we; d_req_addr = a; d_req_size = sz;
    d_req_unsigned = u; d_req_wdata = wd;
    d_req_valid = 1'b1; d_resp_ready = 1'b1;
    ok = d_req_ready;
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
    @(negedge clk);
    ok = ok && d_resp_valid;
    rd = d_resp_rdata;
    er = d_resp_err;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, erd;
    logic [63:0] rd64;
    logic er, ere, ok;

    tbl32[0]  = '{1, 32'h10,  2, 0, 64'h89AB_CDEF, 64'h0,         0};
    tbl32[1]  = '{0, 32'h11,  0, 1, 64'h0,         64'hCD,        0};
    tbl32[2]  = '{0, 32'h13,  0, 0, 64'h0,         64'hFFFF_FF89, 0};
    tbl32[3]  = '{1, 32'h20,  2, 0, 64'hAAAA_AAAA, 64'h0,         0};
    tbl32[4]  = '{1, 32'h22,  1, 0, 64'hFFFF_1234, 64'h0,         0};
    tbl32[5]  = '{0, 32'h20,  2, 0, 64'h0,         64'h1234_AAAA, 0};
    tbl32[6]  = '{1, 32'h00,  2, 0, 64'h5A5A_5A5A, 64'h0,         0};
    tbl32[7]  = '{0, 32'h21,  1, 1, 64'h0,         64'h0,         1};
    tbl32[8]  = '{1, 32'h02,  2, 0, 64'h1111_1111, 64'h0,         1};
    tbl32[9]  = '{0, 32'h00,  2, 0, 64'h0,         64'h5A5A_5A5A, 0};
    tbl32[10] = '{0, 32'h10,  3, 0, 64'h0,         64'h0,         1};
    tbl32[11] = '{0, 32'h100, 2, 0, 64'h0,         64'h0,         1};
    tbl32[12] = '{1, 32'h100, 0, 0, 64'h77,        64'h0,         1};
    tbl32[13] = '{0, 32'h00,  2, 0, 64'h0,         64'h5A5A_5A5A, 0};
    tbl32[14] = '{0, 32'h12,  1, 0, 64'h0,         64'hFFFF_89AB, 0};
    tbl32[15] = '{0, 32'h10,  1, 1, 64'h0,         64'h0000_CDEF, 0};

    tbl64[0] = '{1, 32'h08, 3, 0, 64'h0123_4567_89AB_CDEF, 64'h0, 0};
    tbl64[1] = '{0, 32'h0C, 2, 0, 64'h0, 64'h0000_0000_0123_4567, 0};
    tbl64[2] = '{0, 32'h08, 2, 0, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 0};
    tbl64[3] = '{0, 32'h0F, 0, 1, 64'h0, 64'h01, 0};
    tbl64[4] = '{0, 32'h0A, 1, 0, 64'h0, 64'hFFFF_FFFF_FFFF_89AB, 0};
    tbl64[5] = '{0, 32'h04, 3, 0, 64'h0, 64'h0, 1};
    tbl64[6] = '{0, 32'h80, 2, 0, 64'h0, 64'h0, 1};

    repeat (3) @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst64_resp_valid", d_resp_valid, 0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      xact32(tbl32[i].we, tbl32[i].addr, tbl32[i].size, tbl32[i].uns,
             tbl32[i].wd[31:0], 0, rd, er, ok);
      chk($sformatf("tbl32_%0d_hs", i), ok, 1);
      chk($sformatf("tbl32_%0d_rdata", i), rd, tbl32[i].rd);
      chk($sformatf("tbl32_%0d_err", i), er, tbl32[i].er);
    end

    for (int i = 0; i < 7; i++) begin
      xact64(tbl64[i].we, tbl64[i].addr, tbl64[i].size, tbl64[i].uns,
             tbl64[i].wd, rd64, er, ok);
      chk($sformatf("tbl64_%0d_hs", i), ok, 1);
      chk($sformatf("tbl64_%0d_rdata", i), rd64, tbl64[i].rd);
      chk($sformatf("tbl64_%0d_err", i), er, tbl64[i].er);
    end

    // Stall: load held with resp_ready low while a new request waits.
    xact32(1, 32'h30, 2, 0, 32'hDEAD_BEEF, 0, rd, er, ok);
    @(negedge clk);
    req_we = 0; req_addr = 32'h30; req_size = 2; req_unsigned = 0;
    req_valid = 1; resp_ready = 0;
    chk("stall_ready_before", req_ready, 1);
    @(posedge clk);
    #1;
    req_addr = 32'h10;
    @(negedge clk);
    chk("stall_first_valid", resp_valid, 1);
    chk("stall_first_rdata", resp_rdata, 32'hDEAD_BEEF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall_%0d_rdata", c), resp_rdata, 32'hDEAD_BEEF);
      chk($sformatf("stall_%0d_req_ready", c), req_ready, 0);
      chk($sformatf("stall_%0d_valid", c), resp_valid, 1);
    end
    resp_ready = 1;
    @(posedge clk);
    #1;
    req_valid = 0;
    @(negedge clk);
    chk("release_valid", resp_valid, 1);
    chk("release_rdata", resp_rdata, 32'h89AB_CDEF);

    // Back-to-back store/load, then reset during a pending response.
    @(negedge clk);
    req_we = 1; req_addr = 32'h40; req_size = 0; req_wdata = 32'h55;
    req_valid = 1;
    @(posedge clk);
    #1;
    req_we = 0; req_unsigned = 1;
    @(negedge clk);
    chk("b2b_store_valid", resp_valid, 1);
    chk("b2b_store_rdata", resp_rdata, 0);
    chk("b2b_store_err", resp_err, 0);
    @(posedge clk);
    #1;
    req_we = 1; req_addr = 32'h41; req_wdata = 32'h66;
    @(negedge clk);
    chk("b2b_load_valid", resp_valid, 1);
    chk("b2b_load_rdata", resp_rdata, 32'h55);
    @(posedge clk);
    #1;
    req_valid = 0;
    @(negedge clk);
    chk("b2b_store2_valid", resp_valid, 1);
    rst = 0;
    #1;
    chk("midrst_valid", resp_valid, 0);
    chk("midrst_err", resp_err, 0);
    chk("midrst_rdata", resp_rdata, 0);
    chk("midrst_req_ready", req_ready, 1);
    @(negedge clk);
    rst = 1;
    xact32(0, 32'h41, 0, 1, 0, 0, rd, er, ok);
    chk("postrst_hs", ok, 1);
    chk("postrst_committed", rd, 32'h66);

    // Random traffic against the byte-array model.
    for (int w = 0; w < 64; w++) begin
      logic [31:0] wd;
      wd = $urandom;
      m_do(1, 32'(w * 4), 2, 0, wd, erd, ere);
      xact32(1, 32'(w * 4), 2, 0, wd, 0, rd, er, ok);
      chk("init_hs", ok, 1);
    end
    for (int t = 0; t < 400; t++) begin
      logic [31:0] a, wd;
      logic [1:0] sz;
      logic we, u;
      int st;
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 300));
      if ($urandom_range(0, 9) < 7) a = a & ~(32'(1 << sz) - 1);
      we = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      wd = $urandom;
      st = $urandom_range(0, 2);
      m_do(we, a, sz, u, wd, erd, ere);
      xact32(we, a, sz, u, wd, st, rd, er, ok);
      chk($sformatf("rnd_%0d_hs", t), ok, 1);
      chk($sformatf("rnd_%0d_rdata a=%h sz=%0d", t, a, sz), rd, erd);
      chk($sformatf("rnd_%0d_err a=%h sz=%0d", t, a, sz), er, ere);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
